// File: rtl/m_multicycle_ctrl.sv
// Multi-cycle IF/ID/EX/MA/WB sequencer for the RV32 datapath with req/ack memory handshakes.
// Optional stall performance counter enabled by defining CTRL_PERF_EN.
module m_multicycle_ctrl #(
  parameter logic [7:0] STALL_MAX = 8'd15,
  parameter logic [4:0] HALT_REG  = 5'd30
) (
  input  logic        w_clk,
  input  logic        w_rst,
  input  logic        w_run,
  input  logic [4:0]  w_opcode,
  input  logic [4:0]  w_rd,
  input  logic        w_br_taken,
  input  logic        w_imem_ack,
  input  logic        w_dmem_ack,
  output logic        w_imem_req,
  output logic        w_ir_we,
  output logic        w_pc_we,
  output logic        w_pc_sel,
  output logic        w_rf_we,
  output logic        w_dmem_req,
  output logic        w_dmem_we,
  output logic        w_wb_sel,
  output logic [2:0]  r_state,
  output logic        r_halted,
  output logic        r_timeout,
  output logic [31:0] r_retired,
  output logic [31:0] r_stall_cnt
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_IF   = 3'd1,
    S_ID   = 3'd2,
    S_EX   = 3'd3,
    S_MA   = 3'd4,
    S_WB   = 3'd5,
    S_HALT = 3'd6
  } state_t;

  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_BRANCH = 5'b11000;

  state_t     state_r;
  state_t     state_nxt_s;
  logic [7:0] wait_cnt_r;
  logic       is_load_s;
  logic       is_store_s;
  logic       is_branch_s;
  logic       retire_s;
  logic       timeout_s;
  logic       wait_s;

  assign is_load_s   = (w_opcode == OP_LOAD);
  assign is_store_s  = (w_opcode == OP_STORE);
  assign is_branch_s = (w_opcode == OP_BRANCH);
  assign r_state     = state_r;

  // Next-state, strobe decode and retire/timeout events; everything held low in reset.
  always_comb begin
    state_nxt_s = state_r;
    retire_s    = 1'b0;
    timeout_s   = 1'b0;
    wait_s      = 1'b0;
    w_imem_req  = 1'b0;
    w_ir_we     = 1'b0;
    w_pc_we     = 1'b0;
    w_pc_sel    = 1'b0;
    w_rf_we     = 1'b0;
    w_dmem_req  = 1'b0;
    w_dmem_we   = 1'b0;
    w_wb_sel    = 1'b0;
    if (w_rst) begin
      state_nxt_s = S_IDLE;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (w_run) begin
            state_nxt_s = S_IF;
          end else begin
            state_nxt_s = S_IDLE;
          end
        end
        S_IF: begin
          w_imem_req = 1'b1;
          if (w_imem_ack) begin
            w_ir_we     = 1'b1;
            state_nxt_s = S_ID;
          end else begin
            wait_s = 1'b1;
            if (wait_cnt_r == STALL_MAX) begin
              timeout_s   = 1'b1;
              state_nxt_s = S_HALT;
            end else begin
              state_nxt_s = S_IF;
            end
          end
        end
        S_ID: begin
          state_nxt_s = S_EX;
        end
        S_EX: begin
          if (is_branch_s) begin
            w_pc_we     = 1'b1;
            w_pc_sel    = w_br_taken;
            retire_s    = 1'b1;
            state_nxt_s = S_IF;
          end else if (is_load_s || is_store_s) begin
            state_nxt_s = S_MA;
          end else begin
            state_nxt_s = S_WB;
          end
        end
        S_MA: begin
          w_dmem_req = 1'b1;
          w_dmem_we  = is_store_s;
          if (w_dmem_ack) begin
            if (is_store_s) begin
              w_pc_we     = 1'b1;
              retire_s    = 1'b1;
              state_nxt_s = S_IF;
            end else begin
              state_nxt_s = S_WB;
            end
          end else begin
            wait_s = 1'b1;
            if (wait_cnt_r == STALL_MAX) begin
              timeout_s   = 1'b1;
              state_nxt_s = S_HALT;
            end else begin
              state_nxt_s = S_MA;
            end
          end
        end
        S_WB: begin
          w_rf_we  = 1'b1;
          w_wb_sel = is_load_s;
          w_pc_we  = 1'b1;
          w_pc_sel = 1'b0;
          retire_s = 1'b1;
          if (w_rd == HALT_REG) begin
            state_nxt_s = S_HALT;
          end else begin
            state_nxt_s = S_IF;
          end
        end
        S_HALT: begin
          state_nxt_s = S_HALT;
        end
        default: begin
          state_nxt_s = S_IDLE;
        end
      endcase
    end
  end

  // State register with halt/timeout flags and retired-instruction count.
  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      state_r   <= S_IDLE;
      r_halted  <= 1'b0;
      r_timeout <= 1'b0;
      r_retired <= 32'd0;
    end else begin
      state_r   <= state_nxt_s;
      r_halted  <= (state_nxt_s == S_HALT);
      r_timeout <= r_timeout | timeout_s;
      r_retired <= r_retired + {31'd0, retire_s};
    end
  end

  // Ack wait counter: restarts on every entry into IF or MA.
  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      wait_cnt_r <= 8'd0;
    end else if (((state_nxt_s == S_IF) || (state_nxt_s == S_MA)) && (state_nxt_s != state_r)) begin
      wait_cnt_r <= 8'd0;
    end else if (wait_s && (wait_cnt_r != 8'hFF)) begin
      wait_cnt_r <= wait_cnt_r + 8'd1;
    end else begin
      wait_cnt_r <= wait_cnt_r;
    end
  end

`ifdef CTRL_PERF_EN
  // Saturating count of IF/MA cycles spent without an ack.
  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      r_stall_cnt <= 32'd0;
    end else if (wait_s && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end else begin
      r_stall_cnt <= r_stall_cnt;
    end
  end
`else
  assign r_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_m_multicycle_ctrl.sv
// Self-checking bench for m_multicycle_ctrl: directed and randomized instructions
// compared against a per-instruction stage trace built from the class rules.
module tb_m_multicycle_ctrl;

  logic        w_clk;
  logic        w_rst;
  logic        w_run;
  logic [4:0]  w_opcode;
  logic [4:0]  w_rd;
  logic        w_br_taken;
  logic        w_imem_ack;
  logic        w_dmem_ack;
  logic        w_imem_req;
  logic        w_ir_we;
  logic        w_pc_we;
  logic        w_pc_sel;
  logic        w_rf_we;
  logic        w_dmem_req;
  logic        w_dmem_we;
  logic        w_wb_sel;
  logic [2:0]  r_state;
  logic        r_halted;
  logic        r_timeout;
  logic [31:0] r_retired;
  logic [31:0] r_stall_cnt;

  int          checks;
  int          errors;
  int unsigned retired_exp;
  int unsigned stall_exp;
  logic [7:0]  strb;

  m_multicycle_ctrl dut (
    .w_clk       (w_clk),
    .w_rst       (w_rst),
    .w_run       (w_run),
    .w_opcode    (w_opcode),
    .w_rd        (w_rd),
    .w_br_taken  (w_br_taken),
    .w_imem_ack  (w_imem_ack),
    .w_dmem_ack  (w_dmem_ack),
    .w_imem_req  (w_imem_req),
    .w_ir_we     (w_ir_we),
    .w_pc_we     (w_pc_we),
    .w_pc_sel    (w_pc_sel),
    .w_rf_we     (w_rf_we),
    .w_dmem_req  (w_dmem_req),
    .w_dmem_we   (w_dmem_we),
    .w_wb_sel    (w_wb_sel),
    .r_state     (r_state),
    .r_halted    (r_halted),
    .r_timeout   (r_timeout),
    .r_retired   (r_retired),
    .r_stall_cnt (r_stall_cnt)
  );

  // Strobe bundle: {imem_req, ir_we, pc_we, pc_sel, rf_we, dmem_req, dmem_we, wb_sel}
  assign strb = {w_imem_req, w_ir_we, w_pc_we, w_pc_sel, w_rf_we, w_dmem_req, w_dmem_we, w_wb_sel};

  initial w_clk = 1'b0;
  always #5 w_clk = ~w_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] stall_ref();
`ifdef CTRL_PERF_EN
    return stall_exp;
`else
    return 32'd0;
`endif
  endfunction

  // Called at posedge+1 with inputs set: checks mid-cycle, then advances one clock.
  task automatic cyc(input string tag, input logic [2:0] st, input logic [7:0] sb);
    #4;
    chk({tag, "_state"}, {29'd0, r_state}, {29'd0, st});
    chk({tag, "_strb"}, {24'd0, strb}, {24'd0, sb});
    @(posedge w_clk);
    #1;
  endtask

  task automatic noise();
    w_run      = 1'($urandom_range(0, 1));
    w_imem_ack = 1'($urandom_range(0, 1));
    w_dmem_ack = 1'($urandom_range(0, 1));
    w_br_taken = 1'($urandom_range(0, 1));
  endtask

  task automatic do_reset();
    w_rst = 1'b1; w_run = 1'b1; w_imem_ack = 1'b1; w_dmem_ack = 1'b1;
    #4;
    chk("rst_strb", {24'd0, strb}, 32'd0);
    @(posedge w_clk);
    #1;
    cyc("rst", 3'd0, 8'h00);
    retired_exp = 0;
    stall_exp   = 0;
    chk("rst_retired", r_retired, 32'd0);
    chk("rst_halted", {31'd0, r_halted}, 32'd0);
    chk("rst_timeout", {31'd0, r_timeout}, 32'd0);
    chk("rst_stall", r_stall_cnt, 32'd0);
    w_rst = 1'b0; w_run = 1'b0;
    cyc("idle_hold", 3'd0, 8'h00);
    w_run = 1'b1;
    cyc("idle_run", 3'd0, 8'h00);
  endtask

  // Expected stage trace derived from the instruction class and the ack delays.
  task automatic run_instr(input logic [4:0] op, input logic [4:0] rd, input logic taken,
                           input int d_if, input int d_ma);
    bit ld;
    bit st;
    bit br;
    logic [7:0] sb;
    ld = (op == 5'b00000);
    st = (op == 5'b01000);
    br = (op == 5'b11000);
    w_opcode = op;
    w_rd     = rd;
    for (int k = 0; k <= d_if; k++) begin
      noise();
      w_imem_ack = (k == d_if);
      cyc("if", 3'd1, {1'b1, (k == d_if), 6'b000000});
    end
    stall_exp += d_if;
    noise();
    cyc("id", 3'd2, 8'h00);
    noise();
    w_br_taken = taken;
    sb = 8'h00;
    if (br) sb = {2'b00, 1'b1, taken, 4'b0000};
    cyc("ex", 3'd3, sb);
    if (ld || st) begin
      for (int k = 0; k <= d_ma; k++) begin
        noise();
        w_dmem_ack = (k == d_ma);
        sb = {5'b00000, 1'b1, st, 1'b0};
        if (st && (k == d_ma)) sb = sb | 8'b0010_0000;
        cyc("ma", 3'd4, sb);
      end
      stall_exp += d_ma;
    end
    if (!br && !st) begin
      noise();
      cyc("wb", 3'd5, {4'b0010, 1'b1, 2'b00, ld});
    end
    retired_exp++;
    chk("retired", r_retired, retired_exp);
    chk("stall", r_stall_cnt, stall_ref());
  endtask

  initial begin
    logic [4:0] op;
    logic [4:0] rd;
    int         cls;
    checks = 0; errors = 0; retired_exp = 0; stall_exp = 0;
    w_rst = 1'b1; w_run = 1'b0; w_opcode = 5'd0; w_rd = 5'd0;
    w_br_taken = 1'b0; w_imem_ack = 1'b0; w_dmem_ack = 1'b0;
    @(posedge w_clk);
    #1;
    do_reset();

    run_instr(5'b00100, 5'd1, 1'b0, 0, 0);
    run_instr(5'b11000, 5'd2, 1'b1, 0, 0);
    run_instr(5'b11000, 5'd2, 1'b0, 0, 0);
    run_instr(5'b00000, 5'd5, 1'b0, 0, 3);
    run_instr(5'b01000, 5'd6, 1'b0, 0, 0);
    run_instr(5'b01100, 5'd0, 1'b0, 15, 0);
    run_instr(5'b00000, 5'd7, 1'b0, 2, 15);

    for (int n = 0; n < 40; n++) begin
      cls = $urandom_range(0, 3);
      case (cls)
        0: op = 5'b00000;
        1: op = 5'b01000;
        2: op = 5'b11000;
        default: begin
          op = 5'($urandom_range(0, 31));
          if (op == 5'b00000 || op == 5'b01000 || op == 5'b11000) op = 5'b00100;
        end
      endcase
      rd = 5'($urandom_range(0, 31));
      if (rd == 5'd30) rd = 5'd31;
      run_instr(op, rd, 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3));
    end

    // Instruction fetch never acknowledged: timeout halt after 16 IF cycles.
    w_opcode = 5'b00100; w_rd = 5'd1;
    for (int k = 0; k < 16; k++) begin
      noise();
      w_imem_ack = 1'b0;
      cyc("if_to", 3'd1, 8'b1000_0000);
    end
    stall_exp += 16;
    for (int k = 0; k < 3; k++) begin
      w_run = 1'b1; w_imem_ack = 1'b1; w_dmem_ack = 1'b1;
      cyc("halt_to", 3'd6, 8'h00);
    end
    chk("to_halted", {31'd0, r_halted}, 32'd1);
    chk("to_timeout", {31'd0, r_timeout}, 32'd1);
    chk("to_retired", r_retired, retired_exp);
    chk("to_stall", r_stall_cnt, stall_ref());

    // Writeback to the halt register.
    do_reset();
    run_instr(5'b01100, 5'd30, 1'b0, 0, 0);
    w_run = 1'b1;
    cyc("halt_rd", 3'd6, 8'h00);
    chk("rd_halted", {31'd0, r_halted}, 32'd1);
    chk("rd_timeout", {31'd0, r_timeout}, 32'd0);
    chk("rd_retired", r_retired, 32'd1);

    // Reset in the middle of a load's MA stage.
    do_reset();
    w_opcode = 5'b00000; w_rd = 5'd3; w_imem_ack = 1'b1; w_dmem_ack = 1'b0;
    cyc("mr_if", 3'd1, 8'b1100_0000);
    cyc("mr_id", 3'd2, 8'h00);
    cyc("mr_ex", 3'd3, 8'h00);
    cyc("mr_ma0", 3'd4, 8'b0000_0100);
    cyc("mr_ma1", 3'd4, 8'b0000_0100);
    w_rst = 1'b1; w_dmem_ack = 1'b1;
    cyc("mr_rst", 3'd4, 8'h00);
    w_rst = 1'b0; w_run = 1'b0;
    cyc("mr_idle0", 3'd0, 8'h00);
    cyc("mr_idle1", 3'd0, 8'h00);
    chk("mr_retired", r_retired, 32'd0);
    chk("mr_stall", r_stall_cnt, 32'd0);
    chk("mr_halted", {31'd0, r_halted}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
